// File: rtl/mont_job_arbiter.sv
// Two-requester round-robin arbiter for a shared accumulator datapath: locks one owner per job,
// forwards its operand blocks and routes result blocks back to it.
module mont_job_arbiter #(
   parameter int REGISTER_SIZE  = 32,
   parameter int BLOCKS_PER_NUM = 128
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     req0_valid_in,
   input  logic [REGISTER_SIZE-1:0] req0_data_in,
   output logic                     req0_ready_out,
   input  logic                     req1_valid_in,
   input  logic [REGISTER_SIZE-1:0] req1_data_in,
   output logic                     req1_ready_out,
   output logic                     dp_valid_out,
   output logic [REGISTER_SIZE-1:0] dp_data_out,
   input  logic                     dp_valid_in,
   input  logic [REGISTER_SIZE-1:0] dp_data_in,
   output logic                     res0_valid_out,
   output logic                     res1_valid_out,
   output logic [REGISTER_SIZE-1:0] res_data_out,
   output logic                     grant_out,
   output logic                     busy_out,
   output logic                     err_out,
   output logic [15:0]              jobs_done_out
);

   localparam int CW = (BLOCKS_PER_NUM > 1) ? $clog2(BLOCKS_PER_NUM) : 1;
   localparam logic [CW-1:0] LAST_BLK = CW'(BLOCKS_PER_NUM - 1);

   typedef enum logic [1:0] {IDLE, FEED, WAIT_RESULT} state_t;

   state_t          state_q, state_d;
   logic            grant_q, grant_d;
   logic            last_grant_q, last_grant_d;
   logic [CW-1:0]   in_count_q, in_count_d;
   logic [CW-1:0]   out_count_q, out_count_d;
   logic            err_q, err_d;
   logic [15:0]     jobs_q, jobs_d;
   logic            xfer;
   logic            res_act;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         in_count_q   <= '0;
         out_count_q  <= '0;
         err_q        <= 1'b0;
         jobs_q       <= 16'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         in_count_q   <= in_count_d;
         out_count_q  <= out_count_d;
         err_q        <= err_d;
         jobs_q       <= jobs_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      in_count_d   = in_count_q;
      out_count_d  = out_count_q;
      err_d        = err_q;
      jobs_d       = jobs_q;

      req0_ready_out = (state_q == FEED) && !grant_q;
      req1_ready_out = (state_q == FEED) &&  grant_q;
      xfer           = grant_q ? (req1_valid_in && req1_ready_out)
                               : (req0_valid_in && req0_ready_out);
      dp_valid_out   = xfer;
      dp_data_out    = grant_q ? req1_data_in : req0_data_in;

      // Results only mean something while a job owns the datapath.
      res_act        = (state_q != IDLE) && dp_valid_in;
      res0_valid_out = res_act && !grant_q;
      res1_valid_out = res_act &&  grant_q;
      res_data_out   = dp_data_in;
      busy_out       = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (dp_valid_in) err_d = 1'b1;
            if (req0_valid_in || req1_valid_in) begin
               grant_d = (req0_valid_in && req1_valid_in) ? ~last_grant_q : req1_valid_in;
               state_d = FEED;
            end
         end
         default: begin
            if (xfer) begin
               if (in_count_q == LAST_BLK) begin
                  in_count_d = '0;
                  state_d    = WAIT_RESULT;
               end else begin
                  in_count_d = in_count_q + 1'b1;
               end
            end
            // Final result wins over the final-input transition when both land together.
            if (res_act) begin
               if (out_count_q == LAST_BLK) begin
                  out_count_d  = '0;
                  last_grant_d = grant_q;
                  jobs_d       = jobs_q + 16'd1;
                  state_d      = IDLE;
               end else begin
                  out_count_d = out_count_q + 1'b1;
               end
            end
         end
      endcase
   end

   assign grant_out     = grant_q;
   assign err_out       = err_q;
   assign jobs_done_out = jobs_q;

endmodule

// File: tb/tb_mont_job_arbiter.sv
// Directed bench for mont_job_arbiter with four blocks per operand.
module tb_mont_job_arbiter;
   localparam int RS = 32;
   localparam int NB = 4;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          req_valid [2];
   logic [RS-1:0] req_data  [2];
   logic          req0_ready_out, req1_ready_out;
   logic          dp_valid_out;
   logic [RS-1:0] dp_data_out;
   logic          dp_valid_in;
   logic [RS-1:0] dp_data_in;
   logic          res0_valid_out, res1_valid_out;
   logic [RS-1:0] res_data_out;
   logic          grant_out, busy_out, err_out;
   logic [15:0]   jobs_done_out;

   int checks   = 0;
   int failures = 0;
   int exp_jobs = 0;

   always #5 clk_in = ~clk_in;

   mont_job_arbiter #(.REGISTER_SIZE(RS), .BLOCKS_PER_NUM(NB)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .req0_valid_in(req_valid[0]), .req0_data_in(req_data[0]), .req0_ready_out(req0_ready_out),
      .req1_valid_in(req_valid[1]), .req1_data_in(req_data[1]), .req1_ready_out(req1_ready_out),
      .dp_valid_out(dp_valid_out), .dp_data_out(dp_data_out),
      .dp_valid_in(dp_valid_in), .dp_data_in(dp_data_in),
      .res0_valid_out(res0_valid_out), .res1_valid_out(res1_valid_out), .res_data_out(res_data_out),
      .grant_out(grant_out), .busy_out(busy_out), .err_out(err_out), .jobs_done_out(jobs_done_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Caller has already raised the requester's valid while the arbiter is idle.
   task automatic run_job(input int who, input logic [31:0] base, input int stall_after);
      step();
      chk("grant", grant_out, who);
      chk("busy_feed", busy_out, 1);
      for (int i = 0; i < NB; i++) begin
         if (stall_after > 0 && i == stall_after) begin
            req_valid[who] = 1'b0;
            for (int s = 0; s < 3; s++) begin
               #1;
               chk("stall_dpv", dp_valid_out, 0);
               chk("stall_busy", busy_out, 1);
               step();
            end
            req_valid[who] = 1'b1;
         end
         req_data[who] = base + i;
         #1;
         chk("dp_valid", dp_valid_out, 1);
         chk("dp_data", dp_data_out, base + i);
         chk("rdy_own", (who == 0) ? req0_ready_out : req1_ready_out, 1);
         chk("rdy_other", (who == 0) ? req1_ready_out : req0_ready_out, 0);
         step();
      end
      chk("wait_ready", req0_ready_out | req1_ready_out, 0);
      for (int j = 0; j < NB; j++) begin
         dp_valid_in = 1'b1;
         dp_data_in  = 32'hA500_0000 + base + j;
         #1;
         chk("res_own", (who == 0) ? res0_valid_out : res1_valid_out, 1);
         chk("res_other", (who == 0) ? res1_valid_out : res0_valid_out, 0);
         chk("res_data", res_data_out, 32'hA500_0000 + base + j);
         if (j < NB - 1) chk("busy_res", busy_out, 1);
         step();
      end
      dp_valid_in = 1'b0;
      exp_jobs++;
      chk("busy_done", busy_out, 0);
      chk("jobs", jobs_done_out, exp_jobs);
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      #1;
      chk("rst_busy", busy_out, 0);
      chk("rst_err", err_out, 0);
      chk("rst_jobs", jobs_done_out, 0);
      chk("rst_grant", grant_out, 0);
      chk("rst_rdy", req0_ready_out | req1_ready_out, 0);
      step();
      rst_in = 1'b0;
      exp_jobs = 0;
   endtask

   initial begin
      rst_in = 1'b1;
      req_valid[0] = 0; req_valid[1] = 0;
      req_data[0] = 0;  req_data[1] = 0;
      dp_valid_in = 0;  dp_data_in = 0;
      step();
      do_reset();

      // Single requester job.
      req_valid[0] = 1'b1;
      #1;
      chk("idle_rdy0", req0_ready_out, 0);
      run_job(0, 32'h1, 0);
      req_valid[0] = 1'b0;
      step();

      // Three back-to-back ties from reset alternate 0,1,0.
      do_reset();
      req_valid[0] = 1'b1;
      req_valid[1] = 1'b1;
      req_data[1]  = 32'hDEAD;
      run_job(0, 32'h10, 0);
      run_job(1, 32'h20, 0);
      run_job(0, 32'h30, 0);
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
      step();
      chk("idle_after_ties", busy_out, 0);

      // Stray result while idle is dropped and latches the error.
      dp_valid_in = 1'b1;
      dp_data_in  = 32'h55;
      #1;
      chk("idle_res0", res0_valid_out, 0);
      chk("idle_res1", res1_valid_out, 0);
      step();
      dp_valid_in = 1'b0;
      chk("err_set", err_out, 1);
      req_valid[1] = 1'b1;
      run_job(1, 32'h40, 0);
      req_valid[1] = 1'b0;
      step();
      chk("err_sticky", err_out, 1);

      // Reset in the middle of feeding abandons the job.
      do_reset();
      req_valid[0] = 1'b1;
      step();
      for (int i = 0; i < 2; i++) begin
         req_data[0] = 32'h70 + i;
         step();
      end
      #2;
      rst_in = 1'b1;
      #1;
      chk("mid_rst_busy", busy_out, 0);
      chk("mid_rst_rdy", req0_ready_out, 0);
      chk("mid_rst_dpv", dp_valid_out, 0);
      chk("mid_rst_jobs", jobs_done_out, 0);
      step();
      rst_in = 1'b0;
      exp_jobs = 0;
      run_job(0, 32'h80, 0);

      // Requester stalls for three cycles after block 2.
      run_job(0, 32'h90, 2);
      req_valid[0] = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
